// File: rtl/spgd_pkg.sv
// Shared types and constants for the SPGD two-sided measurement sequencer.
package spgd_pkg;

  localparam int SPGD_MAX_LOG2 = 15;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETTLE_P = 3'd1,
    ACC_P    = 3'd2,
    SETTLE_M = 3'd3,
    ACC_M    = 3'd4,
    DONE_S   = 3'd5
  } state_t;

  // Registered control outputs, always loaded together with the state they describe.
  typedef struct packed {
    logic busy;
    logic perturb_en;
    logic perturb_sign;
    logic done;
  } ctl_t;

  // One extra bit over the worst-case sum keeps the full window sign-safe.
  function automatic int acc_width(input int adc_w, input int max_l);
    return adc_w + max_l + 1;
  endfunction

  function automatic logic [3:0] clamp_log2(input logic [3:0] l, input int max_l);
    if (int'(l) > max_l) begin
      return 4'(max_l);
    end
    return l;
  endfunction

  function automatic ctl_t ctl_of(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      SETTLE_P, ACC_P: begin
        c.busy       = 1'b1;
        c.perturb_en = 1'b1;
      end
      SETTLE_M, ACC_M: begin
        c.busy         = 1'b1;
        c.perturb_en   = 1'b1;
        c.perturb_sign = 1'b1;
      end
      DONE_S: begin
        c.busy = 1'b1;
        c.done = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/spgd_meas_sequencer_if.sv
// Control/sample/result bundle between the SPGD controller and the measurement sequencer.
interface spgd_meas_sequencer_if #(
  parameter int ADC_WIDTH = 12,
  parameter int CNT_WIDTH = 32
);
  logic                        start;
  logic                        abort;
  logic [CNT_WIDTH-1:0]        settle_cycles;
  logic [3:0]                  avg_log2;
  logic signed [ADC_WIDTH-1:0] adc_data;
  logic                        perturb_en;
  logic                        perturb_sign;
  logic                        busy;
  logic                        done;
  logic signed [ADC_WIDTH-1:0] j_plus;
  logic signed [ADC_WIDTH-1:0] j_minus;
  logic signed [ADC_WIDTH:0]   dj;

  modport master (
    output start, abort, settle_cycles, avg_log2, adc_data,
    input  perturb_en, perturb_sign, busy, done, j_plus, j_minus, dj
  );

  modport slave (
    input  start, abort, settle_cycles, avg_log2, adc_data,
    output perturb_en, perturb_sign, busy, done, j_plus, j_minus, dj
  );
endinterface

// File: rtl/spgd_window_avg.sv
// Windowed accumulator: sums sign-extended samples while enabled, clear wins over enable.
// avg is floor((acc + sample) / 2^log2), i.e. the average including the current sample.
module spgd_window_avg
  import spgd_pkg::*;
#(
  parameter int ADC_WIDTH = 12,
  parameter int MAX_LOG2  = SPGD_MAX_LOG2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic                        en,
  input  logic [3:0]                  log2,
  input  logic signed [ADC_WIDTH-1:0] sample,
  output logic signed [ADC_WIDTH-1:0] avg
);
  localparam int ACC_W = acc_width(ADC_WIDTH, MAX_LOG2);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;

  assign sum = acc + {{(ACC_W-ADC_WIDTH){sample[ADC_WIDTH-1]}}, sample};
  assign avg = ADC_WIDTH'(sum >>> log2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end
endmodule

// File: rtl/spgd_meas_sequencer.sv
// Two-sided SPGD measurement: settle/accumulate at +delta, then -delta, then publish J+, J- and dJ.
module spgd_meas_sequencer
  import spgd_pkg::*;
#(
  parameter int ADC_WIDTH = 12,
  parameter int CNT_WIDTH = 32,
  parameter int MAX_LOG2  = SPGD_MAX_LOG2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spgd_meas_sequencer_if.slave  bus
);
  state_t                      state;
  ctl_t                        ctl;
  logic [CNT_WIDTH-1:0]        s_reg;
  logic [CNT_WIDTH-1:0]        cnt;
  logic [3:0]                  l_reg;
  logic signed [ADC_WIDTH-1:0] avg;
  logic signed [ADC_WIDTH-1:0] plus_hold;
  logic signed [ADC_WIDTH-1:0] j_plus_q;
  logic signed [ADC_WIDTH-1:0] j_minus_q;
  logic signed [ADC_WIDTH:0]   dj_q;
  logic                        in_acc;
  logic                        settle_last;
  logic                        acc_last;
  logic                        acc_clr;

  assign in_acc      = (state == ACC_P) || (state == ACC_M);
  assign settle_last = (cnt == s_reg - CNT_WIDTH'(1));
  assign acc_last    = (cnt == (CNT_WIDTH'(1) << l_reg) - CNT_WIDTH'(1));
  // Holding the accumulator cleared outside ACC gives a zero start on every entry,
  // including the direct ACC_P -> ACC_M hop when there is no settle time.
  assign acc_clr     = !in_acc || acc_last;

  spgd_window_avg #(
    .ADC_WIDTH (ADC_WIDTH),
    .MAX_LOG2  (MAX_LOG2)
  ) u_avg (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (acc_clr),
    .en     (in_acc),
    .log2   (l_reg),
    .sample (bus.adc_data),
    .avg    (avg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ctl       <= '0;
      s_reg     <= '0;
      l_reg     <= '0;
      cnt       <= '0;
      plus_hold <= '0;
      j_plus_q  <= '0;
      j_minus_q <= '0;
      dj_q      <= '0;
    end else if (bus.abort && state != IDLE) begin
      state <= IDLE;
      ctl   <= ctl_of(IDLE);
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            s_reg <= bus.settle_cycles;
            l_reg <= clamp_log2(bus.avg_log2, MAX_LOG2);
            cnt   <= '0;
            if (bus.settle_cycles == '0) begin
              state <= ACC_P;
              ctl   <= ctl_of(ACC_P);
            end else begin
              state <= SETTLE_P;
              ctl   <= ctl_of(SETTLE_P);
            end
          end
        end
        SETTLE_P: begin
          if (settle_last) begin
            state <= ACC_P;
            ctl   <= ctl_of(ACC_P);
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        ACC_P: begin
          if (acc_last) begin
            plus_hold <= avg;
            cnt       <= '0;
            if (s_reg == '0) begin
              state <= ACC_M;
              ctl   <= ctl_of(ACC_M);
            end else begin
              state <= SETTLE_M;
              ctl   <= ctl_of(SETTLE_M);
            end
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        SETTLE_M: begin
          if (settle_last) begin
            state <= ACC_M;
            ctl   <= ctl_of(ACC_M);
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        ACC_M: begin
          if (acc_last) begin
            j_plus_q  <= plus_hold;
            j_minus_q <= avg;
            dj_q      <= {plus_hold[ADC_WIDTH-1], plus_hold} - {avg[ADC_WIDTH-1], avg};
            state     <= DONE_S;
            ctl       <= ctl_of(DONE_S);
            cnt       <= '0;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        DONE_S: begin
          state <= IDLE;
          ctl   <= ctl_of(IDLE);
        end
        default: begin
          state <= IDLE;
          ctl   <= ctl_of(IDLE);
        end
      endcase
    end
  end

  assign bus.busy         = ctl.busy;
  assign bus.perturb_en   = ctl.perturb_en;
  assign bus.perturb_sign = ctl.perturb_sign;
  assign bus.done         = ctl.done;
  assign bus.j_plus       = j_plus_q;
  assign bus.j_minus      = j_minus_q;
  assign bus.dj           = dj_q;
endmodule

// File: tb/tb_spgd_meas_sequencer.sv
// Directed bench for the SPGD measurement sequencer; cycle k is the period after edge k, START sampled at edge 0.
module tb_spgd_meas_sequencer;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  spgd_meas_sequencer_if #(.ADC_WIDTH(12), .CNT_WIDTH(32)) bus ();

  spgd_meas_sequencer #(.ADC_WIDTH(12), .CNT_WIDTH(32), .MAX_LOG2(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {busy, perturb_en, perturb_sign, done} in cycle k of a run with settle s and window w.
  function automatic logic [3:0] exp_ctl(input int k, input int s, input int w);
    int d;
    logic [3:0] r;
    d    = 2 * s + 2 * w + 1;
    r[3] = (k >= 1) && (k <= d);
    r[2] = (k >= 1) && (k < d);
    r[1] = (k > s + w) && (k < d);
    r[0] = (k == d);
    return r;
  endfunction

  task automatic run_meas(input string name, input int s, input int l, input int pv, input int mv,
                          input bit alt, input int extra_start, input int ep, input int em, input int edj);
    int w;
    int d;
    int dones;
    logic [3:0] obs;
    w = 1 << l;
    d = 2 * s + 2 * w + 1;
    dones = 0;
    bus.settle_cycles = 32'(s);
    bus.avg_log2 = 4'(l);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 1; k <= d + 3; k++) begin
      bus.start = (k == extra_start);
      if (k <= s + w) bus.adc_data = (alt && (k % 2 == 0)) ? 12'sd0 : 12'(pv);
      else            bus.adc_data = (alt && (k % 2 == 0)) ? 12'sd0 : 12'(mv);
      obs = {bus.busy, bus.perturb_en, bus.perturb_sign, bus.done};
      if (bus.done) dones++;
      total++;
      if (obs !== exp_ctl(k, s, w)) begin
        bad++;
        $display("FAIL %s ctl cycle %0d: got %b want %b", name, k, obs, exp_ctl(k, s, w));
      end
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    total++;
    if (dones !== 1) begin
      bad++;
      $display("FAIL %s done_count: got %0d want 1", name, dones);
    end
    total++;
    if (bus.j_plus !== 12'(ep)) begin
      bad++;
      $display("FAIL %s j_plus: got %0d want %0d", name, bus.j_plus, ep);
    end
    total++;
    if (bus.j_minus !== 12'(em)) begin
      bad++;
      $display("FAIL %s j_minus: got %0d want %0d", name, bus.j_minus, em);
    end
    total++;
    if (bus.dj !== 13'(edj)) begin
      bad++;
      $display("FAIL %s dj: got %0d want %0d", name, bus.dj, edj);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.settle_cycles = '0;
    bus.avg_log2 = '0;
    bus.adc_data = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.busy, bus.perturb_en, bus.perturb_sign, bus.done} !== 4'b0000) begin
      bad++;
      $display("FAIL reset ctl: got %b want 0000", {bus.busy, bus.perturb_en, bus.perturb_sign, bus.done});
    end
    total++;
    if ({bus.j_plus, bus.j_minus, bus.dj} !== 37'd0) begin
      bad++;
      $display("FAIL reset results: got %0d %0d %0d want 0 0 0", bus.j_plus, bus.j_minus, bus.dj);
    end
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_abort_idle();
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    total++;
    if (bus.busy !== 1'b0 || bus.j_plus !== 12'sd100) begin
      bad++;
      $display("FAIL abort_idle: got busy=%b j_plus=%0d want busy=0 j_plus=100", bus.busy, bus.j_plus);
    end
  endtask

  task automatic test_abort();
    logic [3:0] obs;
    logic [3:0] want;
    bus.settle_cycles = 32'd4;
    bus.avg_log2 = 4'd3;
    bus.adc_data = 12'sd100;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      bus.abort = (k == 10);
      obs = {bus.busy, bus.perturb_en, bus.perturb_sign, bus.done};
      want = (k <= 10) ? exp_ctl(k, 4, 8) : 4'b0000;
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL abort ctl cycle %0d: got %b want %b", k, obs, want);
      end
      @(posedge clk);
      #1;
    end
    bus.abort = 1'b0;
    total++;
    if (bus.j_plus !== 12'sd100 || bus.j_minus !== -12'sd50 || bus.dj !== 13'sd150) begin
      bad++;
      $display("FAIL abort held: got %0d %0d %0d want 100 -50 150", bus.j_plus, bus.j_minus, bus.dj);
    end
  endtask

  task automatic test_reset_mid();
    bus.settle_cycles = 32'd1;
    bus.avg_log2 = 4'd1;
    bus.adc_data = 12'sd300;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (bus.perturb_sign !== 1'b1 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid precondition: got sign=%b busy=%b want 1 1", bus.perturb_sign, bus.busy);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.busy, bus.perturb_en, bus.perturb_sign, bus.done} !== 4'b0000 ||
        {bus.j_plus, bus.j_minus, bus.dj} !== 37'd0) begin
      bad++;
      $display("FAIL reset_mid outputs: got ctl=%b res=%0d %0d %0d want all 0",
               {bus.busy, bus.perturb_en, bus.perturb_sign, bus.done}, bus.j_plus, bus.j_minus, bus.dj);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      total++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        bad++;
        $display("FAIL reset_mid release cycle %0d: got busy=%b done=%b want 0 0", k, bus.busy, bus.done);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    run_meas("basic", 4, 3, 100, -50, 1'b0, 0, 100, -50, 150);
    test_abort_idle();
    test_abort();
    run_meas("extremes", 0, 0, -2048, 2047, 1'b0, 0, -2048, 2047, -4095);
    run_meas("floor", 2, 1, -3, 5, 1'b1, 0, -2, 2, -4);
    run_meas("back_to_back", 1, 2, 7, 3, 1'b0, 3, 7, 3, 4);
    run_meas("start_in_done", 0, 1, -9, 11, 1'b0, 5, -9, 11, -20);
    run_meas("long_window", 0, 15, 2047, 2047, 1'b0, 0, 2047, 2047, 0);
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
